// File: rtl/bcd12_to_bin8_if.sv
// Start/busy/done handshake bundle for the BCD-to-binary converter.
// The master side issues start/bcdin; the slave side returns the result and status.
interface bcd12_to_bin8_if #(
  parameter int DIGITS = 3,
  parameter int OUT_W  = 8
);
  logic                  start;
  logic [4*DIGITS-1:0]   bcdin;
  logic [OUT_W-1:0]      numberout;
  logic                  busy;
  logic                  done;
  logic                  err;

  modport master (
    output start, bcdin,
    input  numberout, busy, done, err
  );

  modport slave (
    input  start, bcdin,
    output numberout, busy, done, err
  );
endinterface

// File: rtl/bcd12_to_bin8.sv
// Sequential packed-BCD to binary converter: one multiply-by-10-and-add per digit, MSD first.
// Optional macro BCD12_DIGIT_CHECK_EN flags any digit above 9 as an invalid result.
module bcd12_to_bin8 #(
  parameter int DIGITS = 3,
  parameter int OUT_W  = 8
) (
  input logic            clk,
  input logic            reset,
  bcd12_to_bin8_if.slave bus
);
  localparam int ACC_W = OUT_W + 4;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [ACC_W-1:0] ACC_MAX = {{4{1'b0}}, {OUT_W{1'b1}}};
  localparam logic [ACC_W-1:0] TEN     = ACC_W'(10);

  typedef enum logic {IDLE, CONV} state_t;

  state_t               state;
  logic [4*DIGITS-1:0]  shadow;
  logic [ACC_W-1:0]     acc;
  logic [IDX_W-1:0]     idx;
  logic                 ovf;
  logic                 bad;

  logic [3:0]           digit;
  logic                 digit_bad;
  logic [ACC_W-1:0]     sum;
  logic [ACC_W-1:0]     acc_nxt;
  logic                 ovf_nxt;
  logic                 bad_nxt;

  function automatic logic [ACC_W-1:0] mac10(input logic [ACC_W-1:0] a,
                                             input logic [3:0] d);
    return (a * TEN) + {{(ACC_W-4){1'b0}}, d};
  endfunction

  // The accumulator is clamped on every step so that the next *10 can never wrap.
  function automatic logic [ACC_W-1:0] sat_acc(input logic [ACC_W-1:0] a);
    return (a > ACC_MAX) ? ACC_MAX : a;
  endfunction

  always_comb begin
    digit     = shadow[int'(idx)*4 +: 4];
    digit_bad = 1'b0;
`ifdef BCD12_DIGIT_CHECK_EN
    digit_bad = (digit > 4'd9);
`endif
    sum     = mac10(acc, digit);
    acc_nxt = sat_acc(sum);
    ovf_nxt = ovf | (sum > ACC_MAX);
    bad_nxt = bad | digit_bad;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      shadow        <= '0;
      acc           <= '0;
      idx           <= '0;
      ovf           <= 1'b0;
      bad           <= 1'b0;
      bus.numberout <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.err       <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            shadow   <= bus.bcdin;
            acc      <= '0;
            idx      <= IDX_W'(DIGITS - 1);
            ovf      <= 1'b0;
            bad      <= 1'b0;
            bus.busy <= 1'b1;
            state    <= CONV;
          end
        end
        CONV: begin
          acc <= acc_nxt;
          ovf <= ovf_nxt;
          bad <= bad_nxt;
          if (idx == '0) begin
            bus.numberout <= (ovf_nxt | bad_nxt) ? {OUT_W{1'b1}} : acc_nxt[OUT_W-1:0];
            bus.err       <= ovf_nxt | bad_nxt;
            bus.done      <= 1'b1;
            bus.busy      <= 1'b0;
            state         <= IDLE;
          end else begin
            idx <= idx - IDX_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
